// File: rtl/ccta_result_collector.sv
// Result collector for the CCTA arithmetic stage: a show-ahead FIFO of {ctrl, q}
// pairs drained over valid/ready, plus running sum/max/count statistics.
module ccta_result_collector #(
    parameter int DEPTH = 4,
    parameter int DW    = 5,
    parameter int SUM_W = 9,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    q_in,
    input  logic             ctrl_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_stats,
    output logic [SUM_W-1:0] sum,
    output logic             sum_sat,
    output logic [DW-1:0]    max_q,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [DW:0]      head_q, head_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             sat_q, sat_d;
    logic [DW-1:0]    max_q_q, max_q_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SUM_W:0]   sum_ext;
    logic             push, pop;

    assign full      = (occ_q == (AW+1)'(DEPTH));
    assign empty     = (occ_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = !empty && out_ready;

    assign out_data = head_q;
    assign sum      = sum_q;
    assign sum_sat  = sat_q;
    assign max_q    = max_q_q;
    assign count    = count_q;

    // The head register is loaded with whatever becomes head after this edge,
    // taking the incoming sample directly when it lands in the new head slot.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   occ_d = occ_q + (AW+1)'(1);
            2'b01:   occ_d = occ_q - (AW+1)'(1);
            default: occ_d = occ_q;
        endcase
        if (occ_d == '0)
            head_d = '0;
        else if (push && (rd_ptr_d == wr_ptr_q))
            head_d = {ctrl_in, q_in};
        else
            head_d = mem[rd_ptr_d];
    end

    always_comb begin
        sum_ext = {1'b0, sum_q} + {{(SUM_W+1-DW){1'b0}}, q_in};
        sum_d   = sum_q;
        sat_d   = sat_q;
        max_q_d = max_q_q;
        count_d = count_q;
        if (clr_stats) begin
            sum_d   = push ? SUM_W'(q_in) : '0;
            sat_d   = 1'b0;
            max_q_d = push ? q_in : '0;
            count_d = push ? CNT_W'(1) : '0;
        end else if (push) begin
            sum_d   = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            sat_d   = sat_q | sum_ext[SUM_W];
            max_q_d = (q_in > max_q_q) ? q_in : max_q_q;
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {ctrl_in, q_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            head_q   <= '0;
            sum_q    <= '0;
            sat_q    <= 1'b0;
            max_q_q  <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            sum_q    <= sum_d;
            sat_q    <= sat_d;
            max_q_q  <= max_q_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_ccta_result_collector.sv
// Self-checking bench for ccta_result_collector: constant vector table, directed
// corner sequences and random traffic against a queue-based reference model.
module tb_ccta_result_collector;

    localparam int DEPTH = 4;
    localparam int DW    = 5;
    localparam int SUM_W = 9;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    q_in;
    logic             ctrl_in;
    logic             in_valid;
    logic             in_ready;
    logic [DW:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             clr_stats;
    logic [SUM_W-1:0] sum;
    logic             sum_sat;
    logic [DW-1:0]    max_q;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    int assertCount = 0;
    int failCount   = 0;

    logic [DW:0] mQueue [$];
    int          mSum;
    bit          mSat;
    int          mMax;
    int          mCount;

    typedef struct {
        bit          v;
        logic [4:0]  q;
        bit          c;
        bit          r;
        bit          clr;
        logic [5:0]  expData;
        int          expSum;
        int          expMax;
        int          expCount;
        bit          expEmpty;
    } vec_t;

    vec_t vecs [8];

    ccta_result_collector #(.DEPTH(DEPTH), .DW(DW), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .q_in(q_in), .ctrl_in(ctrl_in), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .clr_stats(clr_stats), .sum(sum), .sum_sat(sum_sat),
        .max_q(max_q), .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string name, input int act, input int exp);
        assertCount++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mQueue.delete();
        mSum   = 0;
        mSat   = 0;
        mMax   = 0;
        mCount = 0;
    endtask

    // Reference behaviour straight from the rules: a queue plus plain integer stats.
    task automatic modelStep(input bit v, input int q, input bit c, input bit r, input bit clr);
        int  maxSum;
        bit  doPush;
        bit  doPop;
        maxSum = (1 << SUM_W) - 1;
        doPush = v && (mQueue.size() < DEPTH);
        doPop  = r && (mQueue.size() > 0);
        if (doPop) void'(mQueue.pop_front());
        if (doPush) mQueue.push_back({c, q[DW-1:0]});
        if (clr) begin
            mSum   = doPush ? q : 0;
            mSat   = 0;
            mMax   = doPush ? q : 0;
            mCount = doPush ? 1 : 0;
        end else if (doPush) begin
            if (mSum + q > maxSum) begin
                mSum = maxSum;
                mSat = 1;
            end else begin
                mSum = mSum + q;
            end
            if (q > mMax) mMax = q;
            mCount = (mCount + 1) % (1 << CNT_W);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic applyStimulus(input bit v, input int q, input bit c, input bit r, input bit clr);
        in_valid  = v;
        q_in      = q[DW-1:0];
        ctrl_in   = c;
        out_ready = r;
        clr_stats = clr;
        @(posedge clk);
        modelStep(v, q, c, r, clr);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        int expData;
        int sz;
        sz      = mQueue.size();
        expData = (sz > 0) ? int'(mQueue[0]) : 0;
        checkValue({tag, "/out_data"},  int'(out_data),  expData);
        checkValue({tag, "/out_valid"}, int'(out_valid), int'(sz > 0));
        checkValue({tag, "/in_ready"},  int'(in_ready),  int'(sz < DEPTH));
        checkValue({tag, "/full"},      int'(full),      int'(sz == DEPTH));
        checkValue({tag, "/empty"},     int'(empty),     int'(sz == 0));
        checkValue({tag, "/sum"},       int'(sum),       mSum);
        checkValue({tag, "/sum_sat"},   int'(sum_sat),   int'(mSat));
        checkValue({tag, "/max_q"},     int'(max_q),     mMax);
        checkValue({tag, "/count"},     int'(count),     mCount);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        q_in      = '0;
        ctrl_in   = 1'b0;
        out_ready = 1'b0;
        clr_stats = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        vecs[0] = '{1, 5'd5,  0, 0, 0, 6'h05, 5,  5,  1, 0};
        vecs[1] = '{1, 5'd17, 1, 0, 0, 6'h05, 22, 17, 2, 0};
        vecs[2] = '{0, 5'd0,  0, 1, 0, 6'h31, 22, 17, 2, 0};
        vecs[3] = '{0, 5'd0,  0, 1, 0, 6'h00, 22, 17, 2, 1};
        vecs[4] = '{0, 5'd0,  0, 0, 1, 6'h00, 0,  0,  0, 1};
        vecs[5] = '{1, 5'd9,  0, 0, 1, 6'h09, 9,  9,  1, 0};
        vecs[6] = '{1, 5'd3,  1, 1, 0, 6'h23, 12, 9,  2, 0};
        vecs[7] = '{0, 5'd0,  0, 1, 0, 6'h00, 12, 9,  2, 1};

        rst = 1'b1;
        doReset();

        // Reset state
        checkValue("rst/empty",     int'(empty),     1);
        checkValue("rst/full",      int'(full),      0);
        checkValue("rst/in_ready",  int'(in_ready),  1);
        checkValue("rst/out_valid", int'(out_valid), 0);
        checkValue("rst/out_data",  int'(out_data),  0);
        checkValue("rst/sum",       int'(sum),       0);
        checkValue("rst/count",     int'(count),     0);
        checkValue("rst/max_q",     int'(max_q),     0);

        // Constant vector table
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].v, int'(vecs[i].q), vecs[i].c, vecs[i].r, vecs[i].clr);
            checkValue($sformatf("vec%0d/out_data", i), int'(out_data), int'(vecs[i].expData));
            checkValue($sformatf("vec%0d/sum", i),      int'(sum),      vecs[i].expSum);
            checkValue($sformatf("vec%0d/max_q", i),    int'(max_q),    vecs[i].expMax);
            checkValue($sformatf("vec%0d/count", i),    int'(count),    vecs[i].expCount);
            checkValue($sformatf("vec%0d/empty", i),    int'(empty),    int'(vecs[i].expEmpty));
            checkOutput($sformatf("vec%0d", i));
        end

        // Fill to full, rejected fifth push, then a sustained push/pop stream
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, i + 1, i % 2, 0, 0);
            checkOutput($sformatf("fill%0d", i));
        end
        checkValue("full/full",     int'(full),     1);
        checkValue("full/in_ready", int'(in_ready), 0);
        applyStimulus(1, 30, 0, 0, 0);
        checkValue("full/count_hold", int'(count), 4);
        checkOutput("full/fifth");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 5 + i, i % 2, 1, 0);
            checkOutput($sformatf("stream%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            checkOutput($sformatf("drain%0d", i));
        end

        // Saturating sum, then a clear that must leave the FIFO alone
        doReset();
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(1, 31, 0, 1, 0);
            checkOutput($sformatf("sat%0d", i));
            if (i >= 17) checkValue($sformatf("sat%0d/sum511", i), int'(sum), 511);
        end
        checkValue("sat/sum_sat", int'(sum_sat), 1);
        checkValue("sat/max_q",   int'(max_q),   31);
        checkValue("sat/count",   int'(count),   20);
        applyStimulus(0, 0, 0, 0, 1);
        checkValue("clr/sum",       int'(sum),       0);
        checkValue("clr/sum_sat",   int'(sum_sat),   0);
        checkValue("clr/out_valid", int'(out_valid), 1);
        checkValue("clr/out_data",  int'(out_data),  'h1F);
        checkOutput("clr");

        // Asynchronous reset between edges with entries buffered
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 10 + i, 1, 0, 0);
        end
        checkOutput("arst/pre");
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkValue("arst/empty",     int'(empty),     1);
        checkValue("arst/out_valid", int'(out_valid), 0);
        checkValue("arst/out_data",  int'(out_data),  0);
        checkValue("arst/count",     int'(count),     0);
        checkValue("arst/sum",       int'(sum),       0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        applyStimulus(0, 0, 0, 1, 0);
        checkValue("arst/pop_blocked", int'(out_valid), 0);
        checkOutput("arst/post");

        // Random traffic against the reference model
        doReset();
        for (int i = 0; i < 400; i++) begin
            bit v, c, r, clr;
            int q;
            v   = ($urandom_range(0, 3) != 0);
            c   = $urandom_range(0, 1);
            r   = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 31) == 0);
            q   = $urandom_range(0, 31);
            applyStimulus(v, q, c, r, clr);
            checkOutput($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
